// File: rtl/div_pkg.sv
// Shared types and constants for the signed 10-by-5 sequential divider.
package div_pkg;
    localparam int W    = 5;
    localparam int DW   = 2 * W;
    localparam int ITER = DW;
    localparam int CW   = $clog2(ITER);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_HI,
        S_LD_LO,
        S_LD_D,
        S_PREP,
        S_ITER,
        S_FIX,
        S_OUT_Q,
        S_OUT_R
    } div_state_t;

    // Two's-complement magnitude; the most negative value maps to its unsigned magnitude.
    function automatic logic [DW-1:0] mag(input logic [DW-1:0] v);
        return v[DW-1] ? (~v + 1'b1) : v;
    endfunction
endpackage

// File: rtl/booth_divider_if.sv
// Narrow word-serial bus shared with the Booth multiplier: start, inbus in; outbus, done, ovf out.
interface booth_divider_if;
    logic                  start;
    logic [div_pkg::W-1:0] inbus;
    logic [div_pkg::W-1:0] outbus;
    logic                  done;
    logic                  ovf;

    modport master (output start, inbus, input outbus, done, ovf);
    modport slave  (input start, inbus, output outbus, done, ovf);
endinterface

// File: rtl/div_datapath.sv
// Operand capture, magnitude conversion, restoring shift/subtract core and sign fix-up.
module div_datapath
    import div_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] inbus,
    input  logic         ld_hi,
    input  logic         ld_lo,
    input  logic         ld_d,
    input  logic         prep,
    input  logic         step,
    input  logic         fix,
    input  logic         sel_q,
    input  logic         sel_r,
    output logic [W-1:0] outbus,
    output logic         ovf_flag
);
    logic [DW-1:0] dvd, a;
    logic [W-1:0]  dvs, b, r, q_r, rm_r;
    logic          qs, rs, dz, ovf_r;

    logic [W:0]    r_sh;
    logic          geq;
    logic [W-1:0]  diff, step_r;
    logic [W-1:0]  q_fix, r_fix;
    logic          ovf_n;

    // R < B <= 16 always holds after a step, so the partial remainder fits W bits;
    // the shifted value needs one extra bit only for the compare.
    always_comb begin
        r_sh   = {r, a[DW-1]};
        geq    = r_sh >= {1'b0, b};
        diff   = r_sh[W-1:0] - b;
        step_r = geq ? diff : r_sh[W-1:0];
        q_fix  = qs ? (~a[W-1:0] + 1'b1) : a[W-1:0];
        r_fix  = rs ? (~r + 1'b1) : r;
        ovf_n  = dz | (!qs && a > DW'(15)) | (qs && a > DW'(16));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd   <= '0;
            dvs   <= '0;
            a     <= '0;
            b     <= '0;
            r     <= '0;
            qs    <= 1'b0;
            rs    <= 1'b0;
            dz    <= 1'b0;
            q_r   <= '0;
            rm_r  <= '0;
            ovf_r <= 1'b0;
        end else begin
            if (ld_hi) dvd[DW-1:W] <= inbus;
            if (ld_lo) dvd[W-1:0]  <= inbus;
            if (ld_d)  dvs         <= inbus;
            if (prep) begin
                a  <= mag(dvd);
                b  <= dvs[W-1] ? (~dvs + 1'b1) : dvs;
                r  <= '0;
                qs <= dvd[DW-1] ^ dvs[W-1];
                rs <= dvd[DW-1];
                dz <= (dvs == '0);
            end
            if (step) begin
                r <= step_r;
                a <= {a[DW-2:0], geq};
            end
            if (fix) begin
                ovf_r <= ovf_n;
                q_r   <= ovf_n ? '0 : q_fix;
                rm_r  <= ovf_n ? '0 : r_fix;
            end
        end
    end

    assign outbus   = sel_q ? q_r : (sel_r ? rm_r : '0);
    assign ovf_flag = ovf_r;
endmodule

// File: rtl/booth_divider.sv
// Signed 10-by-5 divider top: sequencing FSM with registered datapath strobes.
module booth_divider
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    booth_divider_if.slave  bus
);
    div_state_t    state;
    logic [CW-1:0] cnt;
    logic          ld_hi, ld_lo, ld_d, prep, step, fix, sel_q, sel_r;
    logic          ovf_flag;

    // Each strobe is registered alongside the state it belongs to, so it is high
    // for exactly the cycle the FSM spends in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            ld_hi <= 1'b0;
            ld_lo <= 1'b0;
            ld_d  <= 1'b0;
            prep  <= 1'b0;
            step  <= 1'b0;
            fix   <= 1'b0;
            sel_q <= 1'b0;
            sel_r <= 1'b0;
        end else begin
            ld_hi <= 1'b0;
            ld_lo <= 1'b0;
            ld_d  <= 1'b0;
            prep  <= 1'b0;
            step  <= 1'b0;
            fix   <= 1'b0;
            sel_q <= 1'b0;
            sel_r <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    state <= S_LD_HI;
                    ld_hi <= 1'b1;
                end
                S_LD_HI: begin state <= S_LD_LO; ld_lo <= 1'b1; end
                S_LD_LO: begin state <= S_LD_D;  ld_d  <= 1'b1; end
                S_LD_D:  begin state <= S_PREP;  prep  <= 1'b1; end
                S_PREP: begin
                    state <= S_ITER;
                    step  <= 1'b1;
                    cnt   <= CW'(ITER - 1);
                end
                S_ITER: begin
                    if (cnt == '0) begin
                        state <= S_FIX;
                        fix   <= 1'b1;
                    end else begin
                        step <= 1'b1;
                        cnt  <= cnt - 1'b1;
                    end
                end
                S_FIX:   begin state <= S_OUT_Q; sel_q <= 1'b1; end
                S_OUT_Q: begin state <= S_OUT_R; sel_r <= 1'b1; end
                S_OUT_R: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    div_datapath u_dp (
        .clk      (clk),
        .rst      (rst),
        .inbus    (bus.inbus),
        .ld_hi    (ld_hi),
        .ld_lo    (ld_lo),
        .ld_d     (ld_d),
        .prep     (prep),
        .step     (step),
        .fix      (fix),
        .sel_q    (sel_q),
        .sel_r    (sel_r),
        .outbus   (bus.outbus),
        .ovf_flag (ovf_flag)
    );

    assign bus.done = sel_q;
    assign bus.ovf  = (sel_q | sel_r) & ovf_flag;
endmodule
